// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU program sequencer and its helpers.
//   INSTR_W            : width of one CPU instruction word
//   CODE_DEPTH_DEFAULT : default maximum number of words per load session
//   seq_state_e        : sequencer FSM states
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int INSTR_W            = 16;
  localparam int CODE_DEPTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GAP   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cpu_run_timer.sv
// ---------------------------------------------------------------------------
// cpu_run_timer
// Loadable down-counter with a zero flag. The count saturates at zero.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   load       : load load_value into the counter (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one when the count is non-zero
//   zero       : high while the count is zero
// ---------------------------------------------------------------------------
module cpu_run_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; the count never steps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_program_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_program_sequencer
// Runs one clear/load/run session on a small CPU: pulses clear_code, streams
// instruction words into the CPU over a valid/ready handshake, then releases
// the CPU from reset for a programmed number of cycles.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, abort          : begin a session (IDLE only) / drop the session
//   run_cycles            : CPU run length, latched when start is accepted
//   prog_valid/ready/data/last : instruction word stream from the host
//   cpu_clear_code, cpu_getcode, cpu_instruction, cpu_reset_n : CPU controls
//   busy, done            : session in progress / one-cycle end-of-session pulse
//   err_overflow          : sticky, program longer than CODE_DEPTH words
//   word_count            : words loaded in the current session
// ---------------------------------------------------------------------------
module cpu_program_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CODE_DEPTH = CODE_DEPTH_DEFAULT,
  parameter int RUN_W      = 16,
  parameter int CNT_W      = $clog2(CODE_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [RUN_W-1:0]   run_cycles,
  input  logic               prog_valid,
  output logic               prog_ready,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               prog_last,
  output logic               cpu_clear_code,
  output logic               cpu_getcode,
  output logic [INSTR_W-1:0] cpu_instruction,
  output logic               cpu_reset_n,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
  output logic [CNT_W-1:0]   word_count
);

  seq_state_e       state;
  logic [RUN_W-1:0] run_len;
  logic             timer_load;
  logic             timer_zero;

  // The timer is loaded with run_len-1 as RUN is entered, so the zero flag is
  // reached on the last RUN cycle and RUN lasts exactly run_len cycles.
  assign timer_load = (state == ST_GAP) && (run_len != '0);

  cpu_run_timer #(
    .WIDTH (RUN_W)
  ) u_run_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (run_len - RUN_W'(1)),
    .dec        (state == ST_RUN),
    .zero       (timer_zero)
  );

  // Session FSM. All outputs are registered and are updated on the same edge
  // that enters the state they belong to, so each output lines up with the
  // state cycle it describes. getcode, clear_code and done default low, which
  // makes every one of them a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      run_len         <= '0;
      prog_ready      <= 1'b0;
      cpu_clear_code  <= 1'b0;
      cpu_getcode     <= 1'b0;
      cpu_instruction <= '0;
      cpu_reset_n     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_overflow    <= 1'b0;
      word_count      <= '0;
    end else begin
      cpu_getcode    <= 1'b0;
      cpu_clear_code <= 1'b0;
      done           <= 1'b0;

      if (abort && (state != ST_IDLE)) begin
        // Abandon the session; status (err_overflow, word_count) survives.
        state       <= ST_IDLE;
        prog_ready  <= 1'b0;
        cpu_reset_n <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              run_len        <= run_cycles;
              err_overflow   <= 1'b0;
              word_count     <= '0;
              cpu_clear_code <= 1'b1;
              busy           <= 1'b1;
              state          <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            prog_ready <= 1'b1;
            state      <= ST_LOAD;
          end
          ST_LOAD: begin
            if (prog_valid && prog_ready) begin
              cpu_getcode     <= 1'b1;
              cpu_instruction <= prog_data;
              word_count      <= word_count + CNT_W'(1);
              if (prog_last) begin
                prog_ready <= 1'b0;
                state      <= ST_GAP;
              end else if (word_count == CNT_W'(CODE_DEPTH - 1)) begin
                // The buffer is full and more words are coming: give up
                // without ever letting the CPU run a truncated program.
                err_overflow <= 1'b1;
                prog_ready   <= 1'b0;
                done         <= 1'b1;
                state        <= ST_DONE;
              end
            end
          end
          ST_GAP: begin
            if (run_len != '0) begin
              cpu_reset_n <= 1'b1;
              state       <= ST_RUN;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_RUN: begin
            if (timer_zero) begin
              cpu_reset_n <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
